// File: rtl/framebuffer_port_arbiter_pkg.sv
// Shared types and default widths for the framebuffer port arbiter.
// The optional statistics counters are built only when FBARB_STATS_EN is defined.
package framebuffer_port_arbiter_pkg;

  localparam int unsigned BYTE_ADDR_W         = 12;
  localparam int unsigned WORD_ADDR_W         = BYTE_ADDR_W - 1;
  localparam int unsigned BYTE_W              = 8;
  localparam int unsigned WORD_W              = 16;
  localparam int unsigned STALL_W             = 16;
  localparam int unsigned STARVE_EV_W         = 8;
  localparam int unsigned FIFO_DEPTH_LOG2_DEF = 2;
  localparam int unsigned STARVE_LIMIT_DEF    = 8;
  localparam int unsigned STARVE_W_DEF        = 4;

  typedef enum logic [1:0] {
    GNT_IDLE = 2'd0,
    GNT_RD   = 2'd1,
    GNT_WR   = 2'd2
  } grant_e;

  // Queued byte write: {addr, data} = 20 bits
  typedef struct packed {
    logic [BYTE_ADDR_W-1:0] addr;
    logic [BYTE_W-1:0]      data;
  } wr_entry_t;

  // Byte address bit 0 selects the low lane, otherwise the high lane
  function automatic logic [1:0] lane_be(input logic lo_byte);
    return lo_byte ? 2'b01 : 2'b10;
  endfunction

endpackage

// File: rtl/framebuffer_port_arbiter_wfifo.sv
// Synchronous write FIFO for queued byte writes; resets asynchronously to empty.
// o_not_full is registered from the next-state count so a full FIFO never passes through.
module framebuffer_port_arbiter_wfifo
  import framebuffer_port_arbiter_pkg::*;
#(
  parameter int unsigned DEPTH_LOG2 = FIFO_DEPTH_LOG2_DEF
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_push,
  input  wr_entry_t         i_data,
  input  logic              i_pop,
  output wr_entry_t         o_head_c,
  output logic [DEPTH_LOG2:0] o_count,
  output logic              o_not_full
);

  localparam int unsigned DEPTH = 1 << DEPTH_LOG2;
  localparam int unsigned CNT_W = DEPTH_LOG2 + 1;

  wr_entry_t             r_mem [DEPTH];
  logic [DEPTH_LOG2-1:0] r_wr_ptr;
  logic [DEPTH_LOG2-1:0] r_rd_ptr;
  logic [CNT_W-1:0]      r_count;
  logic                  r_not_full;
  logic [CNT_W-1:0]      w_count_nxt;
  logic                  w_push;
  logic                  w_pop;

  assign w_push = i_push && (r_count < CNT_W'(DEPTH));
  assign w_pop  = i_pop && (r_count != '0);

  always_comb begin
    w_count_nxt = r_count;
    if (w_push && !w_pop) begin
      w_count_nxt = r_count + CNT_W'(1);
    end else if (!w_push && w_pop) begin
      w_count_nxt = r_count - CNT_W'(1);
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_count    <= '0;
      r_not_full <= 1'b0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + DEPTH_LOG2'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + DEPTH_LOG2'(1);
      r_count    <= w_count_nxt;
      r_not_full <= (w_count_nxt < CNT_W'(DEPTH));
    end
  end

  // Storage needs no reset; the pointers define what is valid
  always_ff @(posedge i_clk) begin
    if (w_push) r_mem[r_wr_ptr] <= i_data;
  end

  assign o_head_c   = r_mem[r_rd_ptr];
  assign o_count    = r_count;
  assign o_not_full = r_not_full;

endmodule

// File: rtl/framebuffer_port_arbiter.sv
// Shares one single-port 16-bit framebuffer RAM between byte writes (queued) and pixel reads.
// Define FBARB_STATS_EN to build the stall / forced-write statistics counters.
module framebuffer_port_arbiter
  import framebuffer_port_arbiter_pkg::*;
#(
  parameter int unsigned FIFO_DEPTH_LOG2 = FIFO_DEPTH_LOG2_DEF,
  parameter int unsigned STARVE_LIMIT    = STARVE_LIMIT_DEF,
  parameter int unsigned STARVE_W        = STARVE_W_DEF
) (
  input  logic                   i_clk,
  input  logic                   i_rst,
  input  logic                   i_wr_req,
  input  logic [BYTE_ADDR_W-1:0] i_wr_addr,
  input  logic [BYTE_W-1:0]      i_wr_data,
  output logic                   o_wr_ready,
  input  logic                   i_rd_req,
  input  logic [WORD_ADDR_W-1:0] i_rd_addr,
  output logic                   o_rd_ack,
  output logic                   o_rd_valid,
  output logic [WORD_W-1:0]      o_rd_data,
  output logic [WORD_ADDR_W-1:0] o_ram_addr,
  output logic [WORD_W-1:0]      o_ram_wdata,
  output logic [1:0]             o_ram_be,
  output logic                   o_ram_we,
  output logic                   o_ram_ce,
  input  logic [WORD_W-1:0]      i_ram_rdata,
  output logic [STALL_W-1:0]     o_stall_count,
  output logic [STARVE_EV_W-1:0] o_starve_events
);

  wr_entry_t              w_wr_entry;
  wr_entry_t              w_head;
  logic [FIFO_DEPTH_LOG2:0] w_count;
  logic                   w_not_full;
  logic                   w_nonempty;
  logic                   w_starved;
  grant_e                 w_grant;

  logic [WORD_ADDR_W-1:0] r_ram_addr;
  logic [WORD_W-1:0]      r_ram_wdata;
  logic [1:0]             r_ram_be;
  logic                   r_ram_we;
  logic                   r_ram_ce;
  logic                   r_rd_ack;
  logic                   r_rd_valid;
  logic [WORD_W-1:0]      r_rd_hold;
  logic [STARVE_W-1:0]    r_starve_cnt;

  assign w_wr_entry = '{addr: i_wr_addr, data: i_wr_data};

  framebuffer_port_arbiter_wfifo #(
    .DEPTH_LOG2 (FIFO_DEPTH_LOG2)
  ) u_wfifo (
    .i_clk      (i_clk),
    .i_rst      (i_rst),
    .i_push     (i_wr_req && w_not_full),
    .i_data     (w_wr_entry),
    .i_pop      (w_grant == GNT_WR),
    .o_head_c   (w_head),
    .o_count    (w_count),
    .o_not_full (w_not_full)
  );

  assign w_nonempty = (w_count != '0);
  assign w_starved  = w_nonempty && (r_starve_cnt >= STARVE_W'(STARVE_LIMIT));

  // Reads win unless queued writes have waited STARVE_LIMIT read grants
  always_comb begin
    w_grant = GNT_IDLE;
    if (i_rd_req && !w_starved) begin
      w_grant = GNT_RD;
    end else if (w_nonempty) begin
      w_grant = GNT_WR;
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_ram_addr   <= '0;
      r_ram_wdata  <= '0;
      r_ram_be     <= '0;
      r_ram_we     <= 1'b0;
      r_ram_ce     <= 1'b0;
      r_rd_ack     <= 1'b0;
      r_rd_valid   <= 1'b0;
      r_rd_hold    <= '0;
      r_starve_cnt <= '0;
    end else begin
      r_ram_ce <= 1'b0;
      r_ram_we <= 1'b0;
      r_ram_be <= '0;
      r_rd_ack <= 1'b0;
      unique case (w_grant)
        GNT_RD: begin
          r_ram_ce   <= 1'b1;
          r_ram_addr <= i_rd_addr;
          r_rd_ack   <= 1'b1;
        end
        GNT_WR: begin
          r_ram_ce    <= 1'b1;
          r_ram_we    <= 1'b1;
          r_ram_addr  <= w_head.addr[BYTE_ADDR_W-1:1];
          r_ram_wdata <= {w_head.data, w_head.data};
          r_ram_be    <= lane_be(w_head.addr[0]);
        end
        default: ;
      endcase

      if ((w_grant == GNT_WR) || !w_nonempty) begin
        r_starve_cnt <= '0;
      end else if ((w_grant == GNT_RD) && (r_starve_cnt < STARVE_W'(STARVE_LIMIT))) begin
        r_starve_cnt <= r_starve_cnt + STARVE_W'(1);
      end

      r_rd_valid <= r_rd_ack;
      if (r_rd_valid) r_rd_hold <= i_ram_rdata;
    end
  end

  // RAM output is already registered: present it during the valid cycle, then hold it
  assign o_rd_data   = r_rd_valid ? i_ram_rdata : r_rd_hold;
  assign o_rd_valid  = r_rd_valid;
  assign o_rd_ack    = r_rd_ack;
  assign o_wr_ready  = w_not_full;
  assign o_ram_addr  = r_ram_addr;
  assign o_ram_wdata = r_ram_wdata;
  assign o_ram_be    = r_ram_be;
  assign o_ram_we    = r_ram_we;
  assign o_ram_ce    = r_ram_ce;

`ifdef FBARB_STATS_EN
  logic [STALL_W-1:0]     r_stall_count;
  logic [STARVE_EV_W-1:0] r_starve_events;

  // Saturating counters, cleared only by reset
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_stall_count   <= '0;
      r_starve_events <= '0;
    end else begin
      if (i_wr_req && !w_not_full && (r_stall_count != '1)) begin
        r_stall_count <= r_stall_count + STALL_W'(1);
      end
      if ((w_grant == GNT_WR) && i_rd_req && (r_starve_events != '1)) begin
        r_starve_events <= r_starve_events + STARVE_EV_W'(1);
      end
    end
  end

  assign o_stall_count   = r_stall_count;
  assign o_starve_events = r_starve_events;
`else
  assign o_stall_count   = '0;
  assign o_starve_events = '0;
`endif

endmodule

// File: tb/tb_framebuffer_port_arbiter.sv
// Scoreboard bench for framebuffer_port_arbiter: directed stimulus queues expected RAM ops
// and read data; a negedge monitor pops and compares. Follows FBARB_STATS_EN if defined.
module tb_framebuffer_port_arbiter;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        wr_req = 1'b0;
  logic [11:0] wr_addr = '0;
  logic [7:0]  wr_data = '0;
  logic        wr_ready;
  logic        rd_req = 1'b0;
  logic [10:0] rd_addr = '0;
  logic        rd_ack;
  logic        rd_valid;
  logic [15:0] rd_data;
  logic [10:0] ram_addr;
  logic [15:0] ram_wdata;
  logic [1:0]  ram_be;
  logic        ram_we;
  logic        ram_ce;
  logic [15:0] ram_rdata = 16'hDEAD;
  logic [15:0] stall_count;
  logic [7:0]  starve_events;

  always #5 clk = ~clk;

  framebuffer_port_arbiter dut (
    .i_clk           (clk),
    .i_rst           (rst),
    .i_wr_req        (wr_req),
    .i_wr_addr       (wr_addr),
    .i_wr_data       (wr_data),
    .o_wr_ready      (wr_ready),
    .i_rd_req        (rd_req),
    .i_rd_addr       (rd_addr),
    .o_rd_ack        (rd_ack),
    .o_rd_valid      (rd_valid),
    .o_rd_data       (rd_data),
    .o_ram_addr      (ram_addr),
    .o_ram_wdata     (ram_wdata),
    .o_ram_be        (ram_be),
    .o_ram_we        (ram_we),
    .o_ram_ce        (ram_ce),
    .i_ram_rdata     (ram_rdata),
    .o_stall_count   (stall_count),
    .o_starve_events (starve_events)
  );

  typedef struct packed {
    logic        we;
    logic [10:0] addr;
    logic [1:0]  be;
    logic [15:0] wdata;
  } op_t;

  op_t         exp_ops [$];
  logic [15:0] exp_rd [$];
  int          checks = 0;
  int          failures = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic chk_missing(input string name);
    checks++;
    failures++;
    $display("FAIL %s: DUT output with no expected entry queued", name);
  endtask

  // Single-port RAM model: unwritten words read as 0xC000|addr, idle cycles read 0xDEAD
  logic [15:0]  mem [2048];
  bit   [2047:0] wrote;

  function automatic logic [15:0] ram_word(input logic [10:0] a);
    return wrote[a] ? mem[a] : (16'hC000 | 16'(a));
  endfunction

  function automatic logic [15:0] merge(input logic [15:0] old, input logic [15:0] d,
                                        input logic [1:0] be);
    return {be[1] ? d[15:8] : old[15:8], be[0] ? d[7:0] : old[7:0]};
  endfunction

  always @(posedge clk) begin
    ram_rdata <= 16'hDEAD;
    if (ram_ce && ram_we) begin
      mem[ram_addr]   <= merge(ram_word(ram_addr), ram_wdata, ram_be);
      wrote[ram_addr] <= 1'b1;
    end else if (ram_ce) begin
      ram_rdata <= ram_word(ram_addr);
    end
  end

  // Monitor
  op_t  mon_op;
  logic prev_ack = 1'b0;

  always @(negedge clk) begin
    if (rst) begin
      prev_ack <= 1'b0;
    end else begin
      if (ram_ce) begin
        if (exp_ops.size() == 0) begin
          chk_missing("ram_op");
        end else begin
          mon_op = exp_ops.pop_front();
          if (mon_op.we) chk("ram_wr_op", {ram_we, ram_addr, ram_be, ram_wdata}, 32'(mon_op));
          else           chk("ram_rd_op", {ram_we, ram_addr}, {mon_op.we, mon_op.addr});
        end
      end
      if (ram_ce || rd_ack) chk("rd_ack_with_ce", rd_ack, ram_ce && !ram_we);
      if (rd_valid || prev_ack) chk("rd_valid_latency", rd_valid, prev_ack);
      if (rd_valid) begin
        if (exp_rd.size() == 0) chk_missing("rd_data");
        else                    chk("rd_data", rd_data, exp_rd.pop_front());
      end
      prev_ack <= rd_ack;
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic exp_read(input logic [10:0] a, input int n, input logic [15:0] d);
    for (int i = 0; i < n; i++) begin
      exp_ops.push_back('{1'b0, a, 2'b00, 16'h0000});
      exp_rd.push_back(d);
    end
  endtask

  task automatic exp_write(input logic [11:0] ba, input logic [7:0] d);
    exp_ops.push_back('{1'b1, ba[11:1], ba[0] ? 2'b01 : 2'b10, {d, d}});
  endtask

  task automatic drive_wr(input logic [11:0] ba, input logic [7:0] d);
    wr_req  = 1'b1;
    wr_addr = ba;
    wr_data = d;
  endtask

  int cnt_ce;
  int cnt_valid;
  int exp_stall;
  int exp_starve;

  initial begin
    // Reset values
    repeat (3) step();
    chk("reset_wr_ready", wr_ready, 0);
    chk("reset_ram_ctl", {ram_ce, ram_we, ram_be}, 0);
    chk("reset_ram_addr_wdata", {ram_addr, ram_wdata}, 0);
    chk("reset_rd", {rd_ack, rd_valid, rd_data}, 0);
    chk("reset_stats", {stall_count, starve_events}, 0);
    rst = 1'b0;
    step();
    chk("wr_ready_after_reset", wr_ready, 1);
    cnt_ce = 0;
    repeat (20) begin
      step();
      if (ram_ce) cnt_ce++;
    end
    chk("idle_ce_count", cnt_ce, 0);
    chk("idle_rd_outputs", {rd_ack, rd_valid, rd_data}, 0);

    // Two byte writes into word 0x003, then read it back
    exp_write(12'h006, 8'hAB);
    exp_write(12'h007, 8'hCD);
    drive_wr(12'h006, 8'hAB); step();
    drive_wr(12'h007, 8'hCD); step();
    wr_req = 1'b0;
    repeat (3) step();
    exp_read(11'h003, 1, 16'hABCD);
    rd_req = 1'b1; rd_addr = 11'h003; step();
    rd_req = 1'b0;
    repeat (3) step();

    // Starvation: 4 writes queued under a held read, 8 reads then one forced write each
    for (int k = 0; k < 4; k++) begin
      exp_read(11'h010, 8, 16'hC010);
      case (k)
        0: exp_write(12'h040, 8'h11);
        1: exp_write(12'h041, 8'h22);
        2: exp_write(12'h043, 8'h33);
        default: exp_write(12'h044, 8'h44);
      endcase
    end
    drive_wr(12'h040, 8'h11); step();
    rd_req = 1'b1; rd_addr = 11'h010;
    drive_wr(12'h041, 8'h22); step();
    drive_wr(12'h043, 8'h33); step();
    drive_wr(12'h044, 8'h44); step();
    wr_req = 1'b0;
    repeat (33) step();
    rd_req = 1'b0;
    repeat (4) step();

    // Fill the FIFO under a held read; 5th write stalls until the forced write frees a slot
    exp_read(11'h030, 9, 16'hC030);
    exp_write(12'h080, 8'h51);
    exp_read(11'h030, 1, 16'hC030);
    exp_write(12'h081, 8'h52);
    exp_write(12'h082, 8'h53);
    exp_write(12'h083, 8'h54);
    exp_write(12'h084, 8'h55);
    rd_req = 1'b1; rd_addr = 11'h030;
    drive_wr(12'h080, 8'h51); step();
    drive_wr(12'h081, 8'h52); step();
    drive_wr(12'h082, 8'h53); step();
    drive_wr(12'h083, 8'h54); step();
    chk("wr_ready_full", wr_ready, 0);
    drive_wr(12'h084, 8'h55);
    for (int i = 0; i < 6; i++) begin
      step();
      chk("wr_ready_stall", wr_ready, (i == 5) ? 1 : 0);
    end
    step();
    wr_req = 1'b0;
    rd_req = 1'b0;
    repeat (8) step();
`ifdef FBARB_STATS_EN
    exp_stall  = 6;
    exp_starve = 5;
`else
    exp_stall  = 0;
    exp_starve = 0;
`endif
    chk("stall_count", stall_count, exp_stall);
    chk("starve_events", starve_events, exp_starve);

    // Reset while a read is in flight and writes are queued
    exp_read(11'h050, 2, 16'hC050);
    exp_ops.push_back('{1'b0, 11'h050, 2'b00, 16'h0000});
    rd_req = 1'b1; rd_addr = 11'h050;
    drive_wr(12'h0A0, 8'h77); step();
    drive_wr(12'h0A1, 8'h88); step();
    wr_req = 1'b0;
    step();
    rd_req = 1'b0;
    @(negedge clk);
    #1;
    chk("ops_consumed_before_reset", exp_ops.size(), 0);
    chk("rd_consumed_before_reset", exp_rd.size(), 0);
    rst = 1'b1;
    #1;
    chk("reset_drops_ack", {rd_ack, ram_ce}, 0);
    repeat (3) step();
    rst = 1'b0;
    cnt_ce = 0;
    cnt_valid = 0;
    repeat (12) begin
      step();
      if (ram_ce) cnt_ce++;
      if (rd_valid) cnt_valid++;
    end
    chk("post_reset_no_writes", cnt_ce, 0);
    chk("post_reset_no_rd_valid", cnt_valid, 0);
    chk("post_reset_wr_ready", wr_ready, 1);
    chk("post_reset_stats", {stall_count, starve_events}, 0);

    // Read latency and rd_data hold after the valid cycle
    exp_write(12'h0E0, 8'h12);
    exp_write(12'h0E1, 8'h34);
    drive_wr(12'h0E0, 8'h12); step();
    drive_wr(12'h0E1, 8'h34); step();
    wr_req = 1'b0;
    repeat (3) step();
    exp_read(11'h070, 1, 16'h1234);
    rd_req = 1'b1; rd_addr = 11'h070; step();
    rd_req = 1'b0;
    repeat (5) step();
    chk("rd_data_held", rd_data, 16'h1234);
    chk("rd_valid_idle", rd_valid, 0);

    repeat (2) step();
    chk("ops_queue_drained", exp_ops.size(), 0);
    chk("rd_queue_drained", exp_rd.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1);
  end

endmodule
